// File: rtl/spi_initiator.sv
// SPI initiator engine: drives SCLK/SS/MOSI for an injected transaction and
// captures the target's MISO reply. All outputs are registered.
module spi_initiator #(
    parameter int MAX_DATA_SIZE   = 9,
    parameter int CLK_DIV         = 4,
    parameter int DATA_SIZE_WIDTH = $clog2(MAX_DATA_SIZE + 1)
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DATA_SIZE_WIDTH-1:0] data_size,
    input  logic [MAX_DATA_SIZE-1:0]   tx_data,
    input  logic                       miso_in,
    output logic [MAX_DATA_SIZE-1:0]   rx_data,
    output logic                       busy,
    output logic                       done,
    output logic                       sclk_out,
    output logic                       ss_out,
    output logic                       mosi_out
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]           DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DATA_SIZE_WIDTH-1:0] MAX_N    = DATA_SIZE_WIDTH'(MAX_DATA_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t                     state_reg,   state_next;
    logic [DIV_W-1:0]           div_reg,     div_next;
    logic [DATA_SIZE_WIDTH-1:0] bit_reg,     bit_next;
    logic [MAX_DATA_SIZE-1:0]   tx_reg,      tx_next;
    logic [MAX_DATA_SIZE-1:0]   rx_sr_reg,   rx_sr_next;
    logic [MAX_DATA_SIZE-1:0]   rx_data_reg, rx_data_next;
    logic                       sclk_reg,    sclk_next;
    logic                       ss_reg,      ss_next;
    logic                       mosi_reg,    mosi_next;
    logic                       busy_reg,    busy_next;
    logic                       done_reg,    done_next;

    logic [DATA_SIZE_WIDTH-1:0] n_clamped;
    logic [DATA_SIZE_WIDTH-1:0] shamt;
    logic [MAX_DATA_SIZE-1:0]   tx_aligned;
    logic                       div_last;

    // Left-align the word so the MSB to send sits at the top; bits above n fall off.
    assign n_clamped  = (data_size > MAX_N) ? MAX_N : data_size;
    assign shamt      = MAX_N - n_clamped;
    assign tx_aligned = tx_data << shamt;
    assign div_last   = (div_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        div_next     = '0;
        bit_next     = bit_reg;
        tx_next      = tx_reg;
        rx_sr_next   = rx_sr_reg;
        rx_data_next = rx_data_reg;
        sclk_next    = sclk_reg;
        ss_next      = ss_reg;
        mosi_next    = mosi_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        if (state_reg == ST_SETUP || state_reg == ST_SHIFT_HI ||
            state_reg == ST_SHIFT_LO || state_reg == ST_HOLD) begin
            div_next = div_last ? '0 : div_reg + DIV_W'(1);
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    busy_next = 1'b1;
                    bit_next  = n_clamped;
                    if (n_clamped == '0) begin
                        state_next   = ST_DONE;
                        done_next    = 1'b1;
                        rx_data_next = '0;
                    end else begin
                        state_next = ST_SETUP;
                        ss_next    = 1'b1;
                        mosi_next  = tx_aligned[MAX_DATA_SIZE-1];
                        tx_next    = {tx_aligned[MAX_DATA_SIZE-2:0], 1'b0};
                        rx_sr_next = '0;
                    end
                end
            end
            ST_SETUP: begin
                if (div_last) begin
                    state_next = ST_SHIFT_HI;
                    sclk_next  = 1'b1;
                    rx_sr_next = {rx_sr_reg[MAX_DATA_SIZE-2:0], miso_in};
                end
            end
            ST_SHIFT_HI: begin
                if (div_last) begin
                    // tx_reg runs out into zeros, so MOSI drops to 0 after the last bit.
                    state_next = ST_SHIFT_LO;
                    sclk_next  = 1'b0;
                    bit_next   = bit_reg - DATA_SIZE_WIDTH'(1);
                    mosi_next  = tx_reg[MAX_DATA_SIZE-1];
                    tx_next    = {tx_reg[MAX_DATA_SIZE-2:0], 1'b0};
                end
            end
            ST_SHIFT_LO: begin
                if (div_last) begin
                    if (bit_reg == '0) begin
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_SHIFT_HI;
                        sclk_next  = 1'b1;
                        rx_sr_next = {rx_sr_reg[MAX_DATA_SIZE-2:0], miso_in};
                    end
                end
            end
            ST_HOLD: begin
                if (div_last) begin
                    state_next   = ST_DONE;
                    ss_next      = 1'b0;
                    mosi_next    = 1'b0;
                    done_next    = 1'b1;
                    rx_data_next = rx_sr_reg;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            div_reg     <= '0;
            bit_reg     <= '0;
            tx_reg      <= '0;
            rx_sr_reg   <= '0;
            rx_data_reg <= '0;
            sclk_reg    <= 1'b0;
            ss_reg      <= 1'b0;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            bit_reg     <= bit_next;
            tx_reg      <= tx_next;
            rx_sr_reg   <= rx_sr_next;
            rx_data_reg <= rx_data_next;
            sclk_reg    <= sclk_next;
            ss_reg      <= ss_next;
            mosi_reg    <= mosi_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign rx_data  = rx_data_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign sclk_out = sclk_reg;
    assign ss_out   = ss_reg;
    assign mosi_out = mosi_reg;

endmodule

// File: tb/tb_spi_initiator.sv
// Randomised self-checking bench for spi_initiator with a transaction-level
// reference model; one DUT at CLK_DIV=2 and one at CLK_DIV=1.
module tb_spi_initiator;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       start2 = 1'b0;
    logic       start1 = 1'b0;
    logic [3:0] data_size = '0;
    logic [8:0] tx_data = '0;
    logic       miso = 1'b0;

    logic [8:0] rx2, rx1;
    logic       busy2, busy1, done2, done1, sclk2, sclk1, ss2, ss1, mosi2, mosi1;

    int sel = 2;
    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    spi_initiator #(.MAX_DATA_SIZE(9), .CLK_DIV(2)) dut2 (
        .sys_clk(sys_clk), .rst(rst), .start(start2), .data_size(data_size),
        .tx_data(tx_data), .miso_in(miso), .rx_data(rx2), .busy(busy2),
        .done(done2), .sclk_out(sclk2), .ss_out(ss2), .mosi_out(mosi2)
    );

    spi_initiator #(.MAX_DATA_SIZE(9), .CLK_DIV(1)) dut1 (
        .sys_clk(sys_clk), .rst(rst), .start(start1), .data_size(data_size),
        .tx_data(tx_data), .miso_in(miso), .rx_data(rx1), .busy(busy1),
        .done(done1), .sclk_out(sclk1), .ss_out(ss1), .mosi_out(mosi1)
    );

    logic [8:0] rx_m;
    logic       busy_m, done_m, sclk_m, ss_m, mosi_m;
    assign rx_m   = (sel == 1) ? rx1   : rx2;
    assign busy_m = (sel == 1) ? busy1 : busy2;
    assign done_m = (sel == 1) ? done1 : done2;
    assign sclk_m = (sel == 1) ? sclk1 : sclk2;
    assign ss_m   = (sel == 1) ? ss1   : ss2;
    assign mosi_m = (sel == 1) ? mosi1 : mosi2;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 1) start1 = v;
        else        start2 = v;
    endtask

    // One transaction on instance s (CLK_DIV cd). The model predicts timing and
    // data straight from n, tx and the MISO word.
    task automatic run_txn(input int s, input int cd, input logic [3:0] ds,
                           input logic [8:0] tx, input logic [8:0] miso_word,
                           input bit busy_poke, input bit rst_mid, input string tag);
        int n, exp_done, exp_mosi, exp_rx, mask;
        int rises, bad_rise, ss_cnt, done_cnt, done_at, busy_at_done, ss_at_done;
        int busy_after, mosi_got, rx_got, idx;
        bit prev_sclk, aborted;

        n        = (ds > 9) ? 9 : int'(ds);
        mask     = (1 << n) - 1;
        exp_done = (n == 0) ? 1 : 1 + cd * (2 * n + 2);
        exp_mosi = int'(tx) & mask;
        exp_rx   = int'(miso_word) & mask;

        rises = 0; bad_rise = 0; ss_cnt = 0; done_cnt = 0; done_at = -1;
        busy_at_done = 0; ss_at_done = 1; busy_after = 1; mosi_got = 0; rx_got = 0;
        prev_sclk = 1'b0; aborted = 1'b0;

        @(negedge sys_clk);
        sel       = s;
        data_size = ds;
        tx_data   = tx;
        idx       = n - 1;
        miso      = (idx >= 0) ? miso_word[idx] : 1'b0;
        set_start(s, 1'b1);

        for (int k = 1; k <= 300; k++) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            set_start(s, 1'b0);
            if (busy_poke && (k == 5 || k == 20)) begin
                set_start(s, 1'b1);
                tx_data   = 9'($urandom);
                data_size = 4'($urandom_range(1, 12));
            end
            if (ss_m) ss_cnt++;
            if (sclk_m && !prev_sclk) begin
                if (k != 1 + cd * (1 + 2 * rises)) bad_rise++;
                mosi_got = (mosi_got << 1) | int'(mosi_m);
                rises++;
                if (rst_mid && rises == 4) begin
                    rst = 1'b0;
                    #1;
                    check_eq({tag, ".rst_sclk"}, int'(sclk_m), 0);
                    check_eq({tag, ".rst_ss"},   int'(ss_m),   0);
                    check_eq({tag, ".rst_mosi"}, int'(mosi_m), 0);
                    check_eq({tag, ".rst_busy"}, int'(busy_m), 0);
                    check_eq({tag, ".rst_done"}, int'(done_m), 0);
                    check_eq({tag, ".rst_rx"},   int'(rx_m),   0);
                    @(negedge sys_clk);
                    rst = 1'b1;
                    aborted = 1'b1;
                    break;
                end
            end
            if (!sclk_m && prev_sclk) begin
                idx--;
                miso = (idx >= 0) ? miso_word[idx] : 1'b0;
            end
            prev_sclk = sclk_m;
            if (done_m) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = k;
                    busy_at_done = int'(busy_m);
                    ss_at_done   = int'(ss_m);
                    rx_got       = int'(rx_m);
                end
            end
            if (done_at >= 0 && k == done_at + 1) busy_after = int'(busy_m);
            if (done_at >= 0 && k >= done_at + 3) break;
        end

        if (aborted) begin
            $display("txn %s: reset applied at 4th SCLK high phase", tag);
            return;
        end
        check_eq({tag, ".done_at"},      done_at,      exp_done);
        check_eq({tag, ".done_count"},   done_cnt,     1);
        check_eq({tag, ".sclk_pulses"},  rises,        n);
        check_eq({tag, ".rise_timing"},  bad_rise,     0);
        check_eq({tag, ".mosi_bits"},    mosi_got,     exp_mosi);
        check_eq({tag, ".ss_cycles"},    ss_cnt,       (n == 0) ? 0 : cd * (2 * n + 2));
        check_eq({tag, ".rx_data"},      rx_got,       exp_rx);
        check_eq({tag, ".busy_at_done"}, busy_at_done, 1);
        check_eq({tag, ".ss_at_done"},   ss_at_done,   0);
        check_eq({tag, ".busy_after"},   busy_after,   0);
        $display("txn %s: div=%0d n=%0d tx=%03h miso=%03h rx=%03h done_at=T+%0d",
                 tag, cd, n, tx, miso_word, rx_got, done_at);
    endtask

    initial begin
        #1;
        check_eq("reset.busy", int'(busy2), 0);
        check_eq("reset.done", int'(done2), 0);
        check_eq("reset.ss",   int'(ss2),   0);
        check_eq("reset.sclk", int'(sclk2), 0);
        check_eq("reset.mosi", int'(mosi2), 0);
        check_eq("reset.rx",   int'(rx2),   0);
        check_eq("reset.busy1", int'(busy1), 0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b1;

        run_txn(2, 2, 4'd8,  9'h0A5, 9'h03C, 1'b0, 1'b0, "basic");
        run_txn(2, 2, 4'd8,  9'h0A5, 9'h0F0, 1'b0, 1'b1, "reset_mid");
        run_txn(2, 2, 4'd9,  9'h1FF, 9'h000, 1'b0, 1'b0, "max_size");
        run_txn(2, 2, 4'd12, 9'h16B, 9'h1D2, 1'b0, 1'b0, "clamp12");
        run_txn(2, 2, 4'd0,  9'h155, 9'h0FF, 1'b0, 1'b0, "zero_size");
        run_txn(2, 2, 4'd8,  9'h0C3, 9'h05A, 1'b1, 1'b0, "busy_reject");
        run_txn(1, 1, 4'd3,  9'h005, 9'h006, 1'b0, 1'b0, "div1");

        for (int i = 0; i < 10; i++) begin
            int s;
            s = int'($urandom_range(1, 2));
            run_txn(s, (s == 1) ? 1 : 2, 4'($urandom_range(0, 12)), 9'($urandom),
                    9'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_initiator.md
# spi_initiator

Active SPI initiator engine for the MITM datapath. When the controller decides to inject a transaction rather than relay one, this block drives the bus itself: it generates SCLK and SS, shifts a fake word out on MOSI and captures the target's MISO reply. Its bus conventions match the passive buffers:
- SS is active-high and idles low.
- SCLK idles low.
- Data is sampled on SCLK rise and changed on SCLK fall, MSB first.

Its bus outputs feed the `in_line1` side of the output multiplexer.

## Interface
Parameters:
- MAX_DATA_SIZE, 9, maximum bits per transaction.
- CLK_DIV, 4, sys_clk cycles per SCLK half-period. Legal range is 1 or greater.
- DATA_SIZE_WIDTH, $clog2(MAX_DATA_SIZE+1), width of the size field (derived).

Ports:
- sys_clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request; sampled only in IDLE.
- data_size  input  DATA_SIZE_WIDTH  number of bits n; latched on start.
- tx_data  input  MAX_DATA_SIZE  word to send, right-aligned; latched on start.
- miso_in  input  1  target MISO.
- rx_data  output  MAX_DATA_SIZE  received word, right-aligned, upper bits zero.
- busy  output  1  high while a transaction is in progress.
- done  output  1  one-cycle completion pulse.
- sclk_out  output  1  generated SCLK.
- ss_out  output  1  generated SS (active-high).
- mosi_out  output  1  generated MOSI.

## Operation
- Reset values: every output is 0 and the state is IDLE. This applies immediately when rst falls, including mid-transaction; no partial done pulse is produced.
- States and transitions:
  - IDLE: on start, latch n and tx_data, then go to SETUP.
  - SETUP to SHIFT_HI to SHIFT_LO, repeating SHIFT_HI/SHIFT_LO for each bit.
  - After the last bit, go to HOLD, then DONE, then IDLE.
- Clamping: n = min(data_size, MAX_DATA_SIZE).
- Zero size: if n = 0, go straight from IDLE to DONE. SS and SCLK never toggle, and rx_data is cleared to 0.
- SETUP:
  - ss_out = 1 and mosi_out = tx_data[n-1].
  - Hold for CLK_DIV cycles.
- SHIFT_HI (one per bit):
  - On entry, sclk_out = 1.
  - On the same sys_clk edge, shift miso_in into the LSB of the rx shift register.
  - Hold for CLK_DIV cycles.
- SHIFT_LO:
  - On entry, sclk_out = 0.
  - If bits remain, mosi_out takes the next lower tx bit; otherwise mosi_out = 0.
  - Hold for CLK_DIV cycles.
  - After the nth SHIFT_LO, go to HOLD.
- HOLD: SCLK stays low and SS stays high for CLK_DIV cycles.
- DONE (one cycle):
  - ss_out = 0, done = 1, busy = 1.
  - rx_data is updated with the first received bit at position n-1.
  - rx_data then holds until the next transaction's DONE.
- Counters:
  - A divider counter counts 0..CLK_DIV-1.
  - A bit counter of DATA_SIZE_WIDTH bits counts down from n. It cannot wrap.
- Busy handling: start while busy is ignored, with no queuing. tx_data and data_size changes during a transaction have no effect.

## Timing
- Let start be sampled high in IDLE at cycle T, with n ≥ 1.
- T+1: busy = 1, ss_out = 1, mosi_out = MSB.
- Rising SCLK edge k (k = 0..n-1) occurs at T+1+CLK_DIV·(1+2k). Falling edge k occurs CLK_DIV cycles later.
- DONE cycle D = T+1+CLK_DIV·(2n+2). In that cycle ss_out = 0 and done = 1. At D+1, busy = 0 and a new start is accepted.
- Zero size (n = 0): done = 1 and busy = 1 at T+1; idle again at T+2.
- Resulting SCLK period is 2·CLK_DIV. MOSI is stable CLK_DIV cycles before and after each rising edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic transfer:
  - Stimulus: CLK_DIV = 2, n = 8, tx_data = 0x0A5; the bench drives MISO 0x3C MSB-first, updated on SCLK falls.
  - Required: MOSI shows 1,0,1,0,0,1,0,1 at the rises; exactly 8 SCLK pulses; ss_out high for exactly 36 cycles; done at T+37 with rx_data = 0x03C.
- Maximum size:
  - Stimulus: n = 9, tx = 0x1FF, MISO held 0.
  - Required: 9 MOSI ones; rx_data = 0x000; done at T+1+2·20.
- Clamp and zero size:
  - Stimulus: data_size = 12; then data_size = 0.
  - Required: for 12, exactly 9 SCLK pulses. For 0, done pulses at T+1, ss_out never rises, and rx_data = 0.
- Busy rejection:
  - Stimulus: start pulses at T+5 and T+20 during a transaction, with tx_data changed at the same time.
  - Required: the transaction is unaffected and only one done occurs.
- Reset mid-transfer:
  - Stimulus: drop rst during the 4th SCLK high phase.
  - Required: within that cycle sclk_out, ss_out, mosi_out, busy, done and rx_data are all 0. After release, a fresh start works normally.
- Divider extremes:
  - Stimulus: CLK_DIV = 1 with n = 3.
  - Required: SCLK toggles every cycle and done comes at T+9.
